// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: result = r1 - r2 - bi, one bit per clock through a single
// full-subtractor cell with a borrow flip-flop, wrapped in a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  // state   | meaning
  // S_IDLE  | waiting for start; operands captured on the accepting edge
  // S_SHIFT | one difference bit per edge, LSB first
  // S_DONE  | single-cycle done pulse, results valid
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_q, borrow_d, overflow_q, overflow_d, zero_q, zero_d;

  logic             a0, b0, d_bit, br_nxt, last;
  logic [WIDTH-1:0] diff_shift;

  assign a0         = a_q[0];
  assign b0         = b_q[0];
  assign d_bit      = a0 ^ b0 ^ br_q;
  assign br_nxt     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
  assign last       = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last)  state_d = S_DONE;
      S_DONE:             state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_DONE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    br_d       = br_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = r1;
          b_d    = r2;
          br_d   = bi;
          diff_d = '0;
          cnt_d  = '0;
        end
      end
      S_SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nxt;
        diff_d = diff_shift;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          // br_q here is the borrow into the MSB cell
          result_d   = diff_shift;
          borrow_d   = br_nxt;
          overflow_d = br_q ^ br_nxt;
          zero_d     = (diff_shift == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      br_q       <= 1'b0;
      diff_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      br_q       <= br_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result   = result_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random operands against an
// arithmetic reference model, handshake timing, start-ignore and async-reset abort.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] r1 = '0, r2 = '0;
  logic         bi = 1'b0;
  logic         busy, done, borrow, overflow, zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  int exp_res = 0, exp_bor = 0, exp_ov = 0, exp_zero = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .r1(r1), .r2(r2), .bi(bi),
    .busy(busy), .done(done), .result(result), .borrow(borrow),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= M/2) ? v - M : v;
  endfunction

  task automatic model(input int a, input int b, input int c);
    int sd;
    exp_res  = ((a - b - c) % M + M) % M;
    exp_bor  = (a < b + c) ? 1 : 0;
    sd       = to_signed(a) - to_signed(b) - c;
    exp_ov   = (sd < -(M/2) || sd > M/2 - 1) ? 1 : 0;
    exp_zero = (exp_res == 0) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".result"},   int'(result),   exp_res);
    check({tag, ".borrow"},   int'(borrow),   exp_bor);
    check({tag, ".overflow"}, int'(overflow), exp_ov);
    check({tag, ".zero"},     int'(zero),     exp_zero);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  // One full operation; scrambles operands after acceptance and checks latency/hold
  task automatic do_op(input string tag, input int a, input int b, input int c);
    int n = 0;
    int pres = int'(result);
    wait_idle();
    start = 1'b1; r1 = W'(a); r2 = W'(b); bi = c[0];
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_accept"}, int'(busy), 1);
    model(a, b, c);
    while (n < 3*W) begin
      r1 = W'($urandom); r2 = W'($urandom); bi = 1'($urandom);
      @(posedge clk); #1; n++;
      if (done) break;
      if (int'(result) != pres) check({tag, ".hold"}, int'(result), pres);
    end
    check({tag, ".latency"}, n, W);
    check({tag, ".busy_done"}, int'(busy), 1);
    check_outputs(tag);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, int'(done), 0);
    check({tag, ".busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int dcnt, first, prev, ok;
    #12;
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.result", int'(result), 0);
    check("reset.flags", int'({borrow, overflow, zero}), 0);
    @(negedge clk); rst_n = 1'b1;

    do_op("t1", 10, 2, 0);
    check("t1.abs", int'({result, borrow, overflow, zero}), (8 << 3));
    do_op("t2", 2, 10, 0);
    check("t2.abs", int'({result, borrow, overflow, zero}), (8 << 3) | 3'b110);
    do_op("t3", 0, 0, 1);
    do_op("t4", 5, 4, 1);
    check("t4.zero_abs", int'(zero), 1);
    do_op("t5", 7, 8, 0);
    do_op("t6", 8, 1, 0);

    for (int i = 0; i < 40; i++)
      do_op("rand", $urandom_range(0, M-1), $urandom_range(0, M-1), $urandom_range(0, 1));

    // second start while busy must be ignored
    wait_idle();
    start = 1; r1 = 10; r2 = 2; bi = 0;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(negedge clk); start = 1; r1 = 1; r2 = 6; bi = 1;
    @(posedge clk); #1; start = 0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dcnt++;
        check("ignore.result", int'(result), 8);
      end
      @(posedge clk); #1;
    end
    check("ignore.done_count", dcnt, 1);

    // continuous start: one op per W+2 cycles
    wait_idle();
    start = 1; r1 = 9; r2 = 3; bi = 0;
    @(posedge clk); #1;
    dcnt = 0; first = -1; prev = -1; ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (prev >= 0 && i - prev != W + 2) ok = 0;
        if (first < 0) first = i;
        prev = i; dcnt++;
      end
    end
    start = 0;
    check("stream.first_latency", first, W);
    check("stream.spacing_ok", ok, 1);
    check("stream.done_count", dcnt, 3);
    check("stream.result", int'(result), 6);

    // async reset mid-operation
    wait_idle();
    start = 1; r1 = 10; r2 = 2; bi = 0;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0; #1;
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.result", int'(result), 0);
    check("abort.flags", int'({borrow, overflow, zero}), 0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    check("abort.no_done", dcnt, 0);
    do_op("post_reset", 7, 3, 0);
    check("post_reset.abs", int'(result), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing result = r1 − r2 − bi over WIDTH cycles using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the 4-bit ripple adder in the datapath. It trades latency for area and exposes a start/done handshake to the sequencing logic. Outputs include an unsigned borrow-out, a two's-complement overflow flag and a zero flag.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range ≥ 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- r1  input  WIDTH  minuend; captured on the accepting edge.
- r2  input  WIDTH  subtrahend; captured on the accepting edge.
- bi  input  1  borrow in; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse; final results are valid while it is high.
- result  output  WIDTH  (r1 − r2 − bi) mod 2^WIDTH.
- borrow  output  1  1 when r1 < r2 + bi (unsigned).
- overflow  output  1  signed overflow (two's complement).
- zero  output  1  result == 0.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The counter is ceil(log2(WIDTH)) bits wide.
- IDLE with start=1: load the r1, r2 and bi values into internal shift registers a, b and the borrow FF br. Clear the counter and move to SHIFT. When start=0 the FSM stays in IDLE.
- SHIFT, on each edge, with a0 = a[0] and b0 = b[0]:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of the internal difference register.
  - Shift a and b right by one and increment the counter.
- On the edge with counter == WIDTH−1, SHIFT moves to DONE and the output registers load:
  - result = final difference, including the bit d produced on that edge.
  - borrow = br_next.
  - overflow = borrow into MSB XOR br_next.
  - zero = (final difference == 0).
- DONE lasts one cycle, then the FSM returns to IDLE.
- result, borrow, overflow and zero hold their values until the next DONE entry or reset. They do not change during SHIFT.
- start is ignored in SHIFT and DONE, and no queueing occurs. Operand changes after the accepting edge have no effect.
- Simultaneous start and reset: reset wins.

## Timing
- Reset values: state IDLE; busy, done, result, borrow, overflow and zero are all 0; the internal registers are 0.
- Reset asserted mid-operation aborts immediately and asynchronously:
  - Outputs return to their reset values.
  - No done pulse occurs for the aborted operation.
  - The first start is accepted on the first rising edge after rst_n deasserts.
- If start is accepted at edge E0:
  - busy = 1 from E0 until E0+WIDTH+1.
  - SHIFT processes one bit per edge on E0+1 … E0+WIDTH.
  - done = 1 for exactly the cycle between E0+WIDTH and E0+WIDTH+1.
  - The next start can be accepted at E0+WIDTH+2.
- Holding start high continuously gives a throughput of one operation per WIDTH+2 cycles.
- All outputs are registered and have no combinational path from any input.

## Test plan
- WIDTH=4, r1=10, r2=2, bi=0 -> done pulses exactly 4 cycles after the accepting edge; result=8, borrow=0, overflow=0, zero=0.
- r1=2, r2=10, bi=0 -> result=8, borrow=1, overflow=1, zero=0.
- r1=0, r2=0, bi=1 -> result=15, borrow=1, overflow=0, zero=0. Then r1=5, r2=4, bi=1 -> result=0, zero=1, borrow=0.
- Pulse start with r1=10, r2=2, then pulse start again 2 cycles later with different operands -> the second start is ignored, the result is 8, and exactly one done pulse occurs. Holding start high for 20 cycles -> done pulses at 6-cycle spacing.
- After start, change r1/r2/bi every cycle -> the result still reflects the values captured on the accepting edge.
- Drop rst_n 2 cycles after start -> busy, done and all outputs go to 0 at once with no done pulse. After release, r1=7, r2=3, bi=0 -> result=4 with normal latency.
